// File: rtl/mem_bus_bridge_if.sv
// Core-side memory port: byte address, write data and write enable in, read data back.
interface mem_bus_bridge_if;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic [31:0] core_rdata;

    modport master (output core_addr, output core_wdata, output core_we, input core_rdata);
    modport slave  (input core_addr, input core_wdata, input core_we, output core_rdata);
endinterface

// File: rtl/mem_bus_bridge.sv
// Unified word RAM plus MMIO (GPIO, UART transmitter, cycle counter) behind the core's memory port.
// Read data appears one clock after the address; RAM is read-first on collisions.
module mem_bus_bridge #(
    parameter int MEM_WORDS    = 4096,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            resetn,
    mem_bus_bridge_if.slave bus,
    output logic [7:0]      gpio_out,
    output logic            uart_tx
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [1:0]    mmio_off;
    logic          ram_we;
    logic          data_wr;
    logic          status_wr;
    logic          busy;

    assign ram_idx   = bus.core_addr[AW+1:2];
    assign is_mmio   = bus.core_addr[31];
    assign mmio_off  = bus.core_addr[3:2];
    assign ram_we    = bus.core_we && !is_mmio;
    assign data_wr   = bus.core_we && is_mmio && (mmio_off == 2'd1);
    assign status_wr = bus.core_we && is_mmio && (mmio_off == 2'd2);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.core_addr[30:AW+2], bus.core_addr[1:0]};

    // RAM kept free of reset so it maps onto block RAM with its output register.
    logic [31:0] ram [MEM_WORDS];
    logic [31:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.core_wdata;
        end
        ram_rd_q <= ram[ram_idx];
    end

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          sel_ram_q;
    logic [31:0]   mmio_rd_q, mmio_rd_d;
    logic [31:0]   cycles_q;
    logic [7:0]    gpio_q;
    logic          overrun_q, overrun_d;

    assign busy = (state_q != IDLE);

    always_comb begin
        mmio_rd_d = 32'd0;
        case (mmio_off)
            2'd0:    mmio_rd_d = {24'd0, gpio_q};
            2'd1:    mmio_rd_d = 32'd0;
            2'd2:    mmio_rd_d = {30'd0, overrun_q, busy};
            default: mmio_rd_d = cycles_q;
        endcase
    end

    // A status write clears overrun even if an overrun would be flagged on the same edge.
    always_comb begin
        overrun_d = overrun_q;
        if (status_wr) begin
            overrun_d = 1'b0;
        end else if (data_wr && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (data_wr) begin
                    state_d = START;
                    shift_d = bus.core_wdata[7:0];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            sel_ram_q <= 1'b0;
            mmio_rd_q <= 32'd0;
            cycles_q  <= 32'd0;
            gpio_q    <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            sel_ram_q <= !is_mmio;
            mmio_rd_q <= mmio_rd_d;
            cycles_q  <= cycles_q + 32'd1;
            overrun_q <= overrun_d;
            if (bus.core_we && is_mmio && (mmio_off == 2'd0)) begin
                gpio_q <= bus.core_wdata[7:0];
            end
        end
    end

    // Both read sources are registers, so the output never depends on this cycle's inputs.
    assign bus.core_rdata = sel_ram_q ? ram_rd_q : mmio_rd_q;
    assign gpio_out       = gpio_q;
    assign uart_tx        = tx_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized and directed bench for mem_bus_bridge against a cycle-indexed reference model.
module tb_mem_bus_bridge;
    localparam int MW = 64;
    localparam int C  = 4;
    localparam int AW = $clog2(MW);

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] gpio_out;
    logic       uart_tx;

    mem_bus_bridge_if bus_if();

    mem_bus_bridge #(.MEM_WORDS(MW), .CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus_if),
        .gpio_out (gpio_out),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: frame timing is derived from the edge index of the accepting write.
    logic [31:0] mem_m [MW];
    bit          valid_m [MW];
    logic [7:0]  gpio_m;
    bit          ovr_m;
    bit          act_m;
    longint      t0_m;
    longint      n_m;
    logic [7:0]  byte_m;
    logic [31:0] cyc_m;
    logic [31:0] rdata_m;
    bit          rknown_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_busy();
        return act_m && ((n_m - t0_m) <= longint'(10 * C));
    endfunction

    function automatic logic model_tx();
        longint d;
        longint k;
        d = n_m - t0_m;
        if (!act_m || d >= longint'(10 * C)) return 1'b1;
        k = d / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return byte_m[k-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        gpio_m   = 8'd0;
        ovr_m    = 1'b0;
        act_m    = 1'b0;
        t0_m     = 0;
        n_m      = 0;
        cyc_m    = 32'd0;
        rknown_m = 1'b1;
        rdata_m  = 32'd0;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we);
        bit          busy;
        logic [AW-1:0] idx;
        logic        exp_tx;
        bus_if.core_addr  = a;
        bus_if.core_wdata = wd;
        bus_if.core_we    = we;
        @(posedge clk);
        busy = model_busy();
        idx  = a[AW+1:2];
        if (!a[31]) begin
            rknown_m = valid_m[idx];
            rdata_m  = mem_m[idx];
            if (we) begin
                mem_m[idx]   = wd;
                valid_m[idx] = 1'b1;
            end
        end else begin
            rknown_m = 1'b1;
            case (a[3:2])
                2'd0:    rdata_m = {24'd0, gpio_m};
                2'd1:    rdata_m = 32'd0;
                2'd2:    rdata_m = {30'd0, ovr_m, busy};
                default: rdata_m = cyc_m;
            endcase
            if (we) begin
                case (a[3:2])
                    2'd0: gpio_m = wd[7:0];
                    2'd1: begin
                        if (!busy) begin
                            act_m  = 1'b1;
                            t0_m   = n_m;
                            byte_m = wd[7:0];
                        end else begin
                            ovr_m = 1'b1;
                        end
                    end
                    2'd2: ovr_m = 1'b0;
                    default: ;
                endcase
            end
        end
        cyc_m  = cyc_m + 32'd1;
        exp_tx = model_tx();
        n_m++;
        #1;
        if (rknown_m) check_eq("rdata", bus_if.core_rdata, rdata_m);
        check_eq("gpio", {24'd0, gpio_out}, {24'd0, gpio_m});
        check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0000_0000, 32'd0, 1'b0);
    endtask

    logic [31:0] r1;
    logic [31:0] rnd;
    logic [9:0]  tx_seq;

    initial begin
        bus_if.core_addr  = 32'd0;
        bus_if.core_wdata = 32'd0;
        bus_if.core_we    = 1'b0;
        for (int i = 0; i < MW; i++) valid_m[i] = 1'b0;
        byte_m = 8'd0;
        model_reset();

        // Reset held for three edges, released between edges.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", bus_if.core_rdata, 32'd0);
        check_eq("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
        resetn = 1'b1;
        step(32'h8000_0008, 32'd0, 1'b0);
        check_eq("rst_status", bus_if.core_rdata, 32'd0);

        // RAM round trip, alias and read-first collision.
        step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        step(32'h0000_0010, 32'd0, 1'b0);
        check_eq("ram_rd", bus_if.core_rdata, 32'hDEAD_BEEF);
        step(32'h0000_0010 + 4 * MW, 32'd0, 1'b0);
        check_eq("ram_alias", bus_if.core_rdata, 32'hDEAD_BEEF);
        step(32'h0000_0010, 32'h0000_0001, 1'b1);
        check_eq("ram_rfirst", bus_if.core_rdata, 32'hDEAD_BEEF);
        step(32'h0000_0010, 32'd0, 1'b0);
        check_eq("ram_new", bus_if.core_rdata, 32'h0000_0001);

        // GPIO.
        step(32'h8000_0000, 32'h0000_01A5, 1'b1);
        check_eq("gpio_wr", {24'd0, gpio_out}, 32'h0000_00A5);
        step(32'h8000_0000, 32'd0, 1'b0);
        check_eq("gpio_rd", bus_if.core_rdata, 32'h0000_00A5);

        // UART frame of 0x55, sampled once per bit.
        step(32'h8000_0004, 32'h0000_0055, 1'b1);
        tx_seq[0] = uart_tx;
        for (int b = 1; b < 10; b++) begin
            idle(C - 1);
            step(32'h8000_0008, 32'd0, 1'b0);
            tx_seq[b] = uart_tx;
            check_eq("status_busy", bus_if.core_rdata, 32'h1);
        end
        check_eq("frame_55", {22'd0, tx_seq}, 32'h0000_02AA);
        idle(C - 1);
        step(32'h8000_0008, 32'd0, 1'b0);
        step(32'h8000_0008, 32'd0, 1'b0);
        check_eq("status_idle", bus_if.core_rdata, 32'h0);

        // Overrun, status clear, back-to-back frame in the first idle cycle.
        step(32'h8000_0004, 32'h0000_0041, 1'b1);
        idle(2 * C);
        step(32'h8000_0004, 32'h0000_0042, 1'b1);
        step(32'h8000_0008, 32'd0, 1'b0);
        check_eq("status_ovr", bus_if.core_rdata, 32'h3);
        step(32'h8000_0008, 32'd0, 1'b1);
        step(32'h8000_0008, 32'd0, 1'b0);
        check_eq("status_clr", bus_if.core_rdata, 32'h1);
        while (model_busy()) step(32'h0000_0000, 32'd0, 1'b0);
        step(32'h8000_0004, 32'h0000_0011, 1'b1);
        idle(10 * C);
        step(32'h8000_0004, 32'h0000_0022, 1'b1);
        check_eq("b2b_start", {31'd0, uart_tx}, 32'd0);
        idle(10 * C + 2);

        // Cycle counter spacing and wrap.
        step(32'h8000_000C, 32'd0, 1'b0);
        r1 = bus_if.core_rdata;
        idle(4);
        step(32'h8000_000C, 32'd0, 1'b0);
        check_eq("cyc_diff", bus_if.core_rdata - r1, 32'd5);
        #1;
        force dut.cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycles_q;
        cyc_m = 32'hFFFF_FFFF;
        step(32'h8000_000C, 32'd0, 1'b0);
        check_eq("cyc_max", bus_if.core_rdata, 32'hFFFF_FFFF);
        step(32'h8000_000C, 32'd0, 1'b0);
        check_eq("cyc_wrap", bus_if.core_rdata, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            logic [31:0] w;
            rnd = $urandom;
            w   = $urandom;
            if (rnd[3:0] < 4'd9) a = {1'b0, rnd[30:0]};
            else a = {1'b1, rnd[30:4], rnd[5:4], rnd[1:0]};
            step(a, w, rnd[31] & rnd[30]);
        end

        // Asynchronous reset mid-frame at bit 3.
        step(32'h8000_0000, 32'h0000_005A, 1'b1);
        while (model_busy()) step(32'h0000_0000, 32'd0, 1'b0);
        step(32'h8000_0004, 32'h0000_0000, 1'b1);
        idle(4 * C - 1);
        check_eq("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_tx", {31'd0, uart_tx}, 32'd1);
        check_eq("arst_gpio", {24'd0, gpio_out}, 32'd0);
        check_eq("arst_rdata", bus_if.core_rdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        step(32'h8000_0008, 32'd0, 1'b0);
        check_eq("arst_status", bus_if.core_rdata, 32'd0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
